dcache_sram_arbiter: RTL and testbench

- Shares the single data/tag SRAM access port of the non-blocking L1 dcache among NR_PORTS requesters.
- Port 0 (miss handler) has fixed priority. Ports 1..NR_PORTS-1 (PTW, load, store controllers) are round-robin.
- Per-port starvation counters bound the wait of every round-robin port.
- Read data returns one cycle after grant, steered to the granted port.

---
 rtl/dcache_sram_arbiter.sv | 155 +++++++++++++++
 tb/tb_dcache_sram_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_sram_arbiter.sv
// Arbiter for the shared L1 dcache data/tag SRAM port: fixed-priority port 0,
// round-robin ports 1..NR_PORTS-1, starvation override, and one-cycle read return.
module dcache_sram_arbiter #(
    parameter int NR_PORTS     = 4,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 128,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clr_i,
    input  logic [NR_PORTS-1:0]              req_i,
    input  logic [NR_PORTS-1:0]              we_i,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NR_PORTS*DATA_WIDTH-1:0]   wdata_i,
    output logic [NR_PORTS-1:0]              gnt_o,
    output logic [NR_PORTS-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             ram_req_o,
    output logic                             ram_we_o,
    output logic [ADDR_WIDTH-1:0]            ram_addr_o,
    output logic [DATA_WIDTH-1:0]            ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]            ram_rdata_i,
    output logic                             starve_o
);

    localparam int PTR_W = $clog2(NR_PORTS);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [PTR_W-1:0]      r_rr_ptr;
    logic [NR_PORTS-1:0]   r_rvalid;
    logic [CNT_W-1:0]      r_wait [NR_PORTS];

    logic [NR_PORTS-1:0]   w_starve_mask;
    logic [NR_PORTS-1:0]   w_req_rr;
    logic [NR_PORTS-1:0]   w_starve_pick;
    logic [NR_PORTS-1:0]   w_rr_pick;
    logic [NR_PORTS-1:0]   w_gnt;
    logic                  w_starve;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic [PTR_W-1:0]      w_rr_ptr_nxt;
    logic                  w_ram_we;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;

    // First set bit of mask among ports 1..NR_PORTS-1, scanning from ptr with wrap.
    function automatic logic [NR_PORTS-1:0] rr_pick(input logic [NR_PORTS-1:0] mask,
                                                    input logic [PTR_W-1:0]    ptr);
        logic [NR_PORTS-1:0] sel;
        logic                found;
        int                  idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NR_PORTS - 1; k++) begin
            idx = ((int'(ptr) - 1 + k) % (NR_PORTS - 1)) + 1;
            if (!found && mask[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        w_starve_mask = '0;
        w_req_rr      = req_i;
        w_req_rr[0]   = 1'b0;
        for (int i = 1; i < NR_PORTS; i++) begin
            w_starve_mask[i] = req_i[i] && (r_wait[i] == LIMIT);
        end
    end

    assign w_starve_pick = rr_pick(w_starve_mask, r_rr_ptr);
    assign w_rr_pick     = rr_pick(w_req_rr, r_rr_ptr);

    // Grants are suppressed while reset is held so the SRAM sees no request.
    always_comb begin
        w_gnt    = '0;
        w_starve = 1'b0;
        if (!rst_ni) begin
            w_gnt = '0;
        end else if (|w_starve_mask) begin
            w_gnt    = w_starve_pick;
            w_starve = 1'b1;
        end else if (req_i[0]) begin
            w_gnt[0] = 1'b1;
        end else begin
            w_gnt = w_rr_pick;
        end
    end

    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        w_gnt_idx   = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            if (w_gnt[i]) begin
                w_ram_we    = we_i[i];
                w_ram_addr  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_ram_wdata = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                w_gnt_idx   = PTR_W'(i);
            end
        end
    end

    always_comb begin
        w_rr_ptr_nxt = r_rr_ptr;
        if (|w_gnt[NR_PORTS-1:1]) begin
            if (w_gnt_idx == PTR_W'(NR_PORTS - 1)) begin
                w_rr_ptr_nxt = PTR_W'(1);
            end else begin
                w_rr_ptr_nxt = w_gnt_idx + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= PTR_W'(1);
            r_rvalid <= '0;
            for (int i = 0; i < NR_PORTS; i++) begin
                r_wait[i] <= '0;
            end
        end else if (clr_i) begin
            r_rr_ptr <= PTR_W'(1);
            r_rvalid <= '0;
            for (int i = 0; i < NR_PORTS; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
            r_rvalid <= w_gnt & ~we_i;
            for (int i = 0; i < NR_PORTS; i++) begin
                // Port 0 never waits; its slot stays at zero.
                if (i == 0 || w_gnt[i] || !req_i[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != LIMIT) begin
                    r_wait[i] <= r_wait[i] + CNT_W'(1);
                end
            end
        end
    end

    assign gnt_o       = w_gnt;
    assign starve_o    = w_starve;
    assign ram_req_o   = |w_gnt;
    assign ram_we_o    = w_ram_we;
    assign ram_addr_o  = w_ram_addr;
    assign ram_wdata_o = w_ram_wdata;
    assign rvalid_o    = r_rvalid;
    assign rdata_o     = ram_rdata_i;

endmodule

// File: tb/tb_dcache_sram_arbiter.sv
// Directed bench for dcache_sram_arbiter: a cycle-by-cycle vector table plus
// hand-built reset/clear corner sequences.
module tb_dcache_sram_arbiter;

    localparam int NP = 4;
    localparam int AW = 12;
    localparam int DW = 128;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic [NP-1:0]     req;
    logic [NP-1:0]     we;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  wdata;
    logic [NP-1:0]     gnt;
    logic [NP-1:0]     rvalid;
    logic [DW-1:0]     rdata;
    logic              ram_req;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_rdata;
    logic              starve;

    int n_checks;
    int n_err;

    logic [AW-1:0] paddr [NP] = '{12'hA00, 12'h111, 12'h040, 12'h333};
    logic [DW-1:0] pdata [NP] = '{ {4{32'hD0D0_0000}}, {4{32'hD0D0_0001}},
                                   {4{32'hD0D0_0002}}, {4{32'hD0D0_0003}} };

    typedef struct {
        logic [NP-1:0] req;
        logic [NP-1:0] we;
        logic          clr;
        logic [NP-1:0] gnt;
        logic          starve;
        logic [NP-1:0] rvalid;
    } vec_t;

    vec_t vecs[$];

    dcache_sram_arbiter #(
        .NR_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .starve_o(starve)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [NP-1:0] r, input logic [NP-1:0] w, input logic c,
                       input logic [NP-1:0] g, input logic s, input logic [NP-1:0] rv);
        vec_t v;
        v.req = r; v.we = w; v.clr = c; v.gnt = g; v.starve = s; v.rvalid = rv;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [NP-1:0] r, input logic [NP-1:0] w, input logic c);
        req = r;
        we  = w;
        clr = c;
        ram_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic check_outputs(input string tag, input logic [NP-1:0] eg,
                                 input logic es, input logic [NP-1:0] erv);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        ea = '0;
        ed = '0;
        for (int p = 0; p < NP; p++) begin
            if (eg[p]) begin
                ea = paddr[p];
                ed = pdata[p];
            end
        end
        chk({tag, " gnt"}, DW'(gnt), DW'(eg));
        chk({tag, " starve"}, DW'(starve), DW'(es));
        chk({tag, " rvalid"}, DW'(rvalid), DW'(erv));
        chk({tag, " ram_req"}, DW'(ram_req), DW'(|eg));
        chk({tag, " ram_we"}, DW'(ram_we), DW'(|(eg & we)));
        chk({tag, " ram_addr"}, DW'(ram_addr), DW'(ea));
        chk({tag, " ram_wdata"}, ram_wdata, ed);
        if (|erv) chk({tag, " rdata"}, rdata, ram_rdata);
    endtask

    // Build up rr_ptr and a waiting counter, then wipe them with reset or clear.
    task automatic corner(input bit use_clr);
        string t;
        t = use_clr ? "clr" : "rst";
        @(negedge clk); drive(4'b0100, 4'b0000, 1'b0); #2;
        check_outputs({t, " c1"}, 4'b0100, 1'b0, 4'b0000);
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            drive(4'b1011, 4'b0000, (use_clr && k == 7) ? 1'b1 : 1'b0);
            #2;
            check_outputs($sformatf("%s c%0d", t, k), 4'b0001, 1'b0,
                          (k == 2) ? 4'b0100 : 4'b0001);
        end
        if (!use_clr) begin
            rst_n = 1'b0;
            #1;
            chk("rst gnt during reset", DW'(gnt), '0);
            chk("rst ram_req during reset", DW'(ram_req), '0);
            @(posedge clk);
            #1 rst_n = 1'b1;
        end
        @(negedge clk); drive(4'b1110, 4'b0000, 1'b0); #2;
        check_outputs({t, " c8"}, 4'b0010, 1'b0, 4'b0000);
        for (int k = 9; k <= 15; k++) begin
            @(negedge clk); drive(4'b1001, 4'b0000, 1'b0); #2;
            check_outputs($sformatf("%s c%0d", t, k), 4'b0001, 1'b0,
                          (k == 9) ? 4'b0010 : 4'b0001);
        end
        @(negedge clk); drive(4'b1001, 4'b0000, 1'b0); #2;
        check_outputs({t, " c16"}, 4'b1000, 1'b1, 4'b0001);
        @(negedge clk); drive(4'b0000, 4'b0000, 1'b0); #2;
        check_outputs({t, " c17"}, 4'b0000, 1'b0, 4'b1000);
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        req       = '0;
        we        = '0;
        ram_rdata = '0;
        for (int p = 0; p < NP; p++) begin
            addr[p*AW +: AW]  = paddr[p];
            wdata[p*DW +: DW] = pdata[p];
        end

        // single port-2 read, then clear
        add(4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0000);
        add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0100);
        add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000);
        // ports 1..3 round robin
        add(4'b1110, 4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0000);
        add(4'b1110, 4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0010);
        add(4'b1110, 4'b0000, 1'b0, 4'b1000, 1'b0, 4'b0100);
        add(4'b1110, 4'b0000, 1'b0, 4'b0010, 1'b0, 4'b1000);
        add(4'b1110, 4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0010);
        add(4'b1110, 4'b0000, 1'b0, 4'b1000, 1'b0, 4'b0100);
        add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b1000);
        // port 0 vs port 1: eight port-0 wins then a starvation grant
        add(4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000);
        for (int k = 0; k < 7; k++) add(4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0001);
        add(4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b1, 4'b0001);
        add(4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0010);
        add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0001);
        // port 3 write then port 1 read
        add(4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b0, 4'b0000);
        add(4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 4'b0000);
        add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0010);
        // ports 1 and 3 starve together with rr_ptr=2
        add(4'b1011, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000);
        for (int k = 0; k < 7; k++) add(4'b1011, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0001);
        add(4'b1011, 4'b0000, 1'b0, 4'b1000, 1'b1, 4'b0001);
        add(4'b1011, 4'b0000, 1'b0, 4'b0010, 1'b1, 4'b1000);
        add(4'b1011, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0010);
        add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0001);

        #2;
        req = 4'b1111;
        #1;
        chk("reset gnt", DW'(gnt), '0);
        chk("reset ram_req", DW'(ram_req), '0);
        chk("reset rvalid", DW'(rvalid), '0);
        chk("reset starve", DW'(starve), '0);
        req = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].req, vecs[i].we, vecs[i].clr);
            #2;
            check_outputs($sformatf("row%0d", i), vecs[i].gnt, vecs[i].starve, vecs[i].rvalid);
        end

        corner(1'b0);
        corner(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
